// File: rtl/apb_requester.sv
`default_nettype none
// ============================================================================
// Module   : apb_requester
// Purpose  : Takes one read/write command on a valid/ready port and runs it as
//            an APB SETUP/ACCESS transfer, then returns a one-cycle response.
//            Optional build macro: APB_REQ_DECODE_EN (one-hot select decode).
// Revision : 1.0 - initial release
// ============================================================================
module apb_requester #(
    parameter int AddrWidth    = 32,
    parameter int DataWidth    = 32
`ifdef APB_REQ_DECODE_EN
    ,
    parameter int SubAddrWidth = 4,
    parameter int NumSubs      = 4
`endif
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [AddrWidth-1:0] req_addr,
    input  logic [DataWidth-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [DataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
`ifdef APB_REQ_DECODE_EN
    output logic [NumSubs-1:0]   sel,
`else
    output logic                 sel,
`endif
    output logic                 enable,
    output logic                 write,
    output logic [AddrWidth-1:0] addr,
    output logic [DataWidth-1:0] wData,
    input  logic [DataWidth-1:0] rData,
    input  logic                 subErr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t r_state;
    logic   r_ready;
    logic   r_is_write;
    logic   r_dec_err;
    logic   r_err_base;

    logic                 w_dec_err;
    logic [AddrWidth-1:0] w_addr;
`ifdef APB_REQ_DECODE_EN
    localparam int IdxW = $clog2(NumSubs);
    logic [NumSubs-1:0] w_sel;
    logic [IdxW-1:0]    w_idx;

    always_comb begin
        w_idx     = req_addr[SubAddrWidth +: IdxW];
        // Any address bit above the select field means no peripheral answers.
        w_dec_err = |(req_addr >> (SubAddrWidth + IdxW));
        w_sel     = w_dec_err ? '0 : (NumSubs'(1) << w_idx);
        w_addr    = '0;
        w_addr[SubAddrWidth-1:0] = req_addr[SubAddrWidth-1:0];
    end
`else
    logic w_sel;

    always_comb begin
        w_sel     = 1'b1;
        w_dec_err = 1'b0;
        w_addr    = req_addr;
    end
`endif

    assign req_ready = r_ready & nReset;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_state    <= IDLE;
            r_ready    <= 1'b0;
            r_is_write <= 1'b0;
            r_dec_err  <= 1'b0;
            r_err_base <= 1'b0;
            sel        <= '0;
            enable     <= 1'b0;
            write      <= 1'b0;
            addr       <= '0;
            wData      <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    r_ready   <= 1'b1;
                    if (req_valid && r_ready) begin
                        r_state    <= SETUP;
                        r_ready    <= 1'b0;
                        r_is_write <= req_write;
                        r_dec_err  <= w_dec_err;
                        sel        <= w_sel;
                        write      <= req_write;
                        addr       <= w_addr;
                        wData      <= req_wdata;
                    end
                end
                SETUP: begin
                    r_state <= ACCESS;
                    enable  <= 1'b1;
                end
                ACCESS: begin
                    // Baseline lets a sticky peripheral error fail only the
                    // transfer that raised it.
                    r_err_base <= subErr;
                    r_state    <= CAPTURE;
                    sel        <= '0;
                    enable     <= 1'b0;
                    write      <= 1'b0;
                    addr       <= '0;
                    wData      <= '0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_ready   <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= (r_is_write || r_dec_err) ? '0 : rData;
                    rsp_err   <= r_dec_err | (subErr & ~r_err_base);
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_requester
// Purpose  : Directed bench for apb_requester with a peripheral model and a
//            response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_requester;

`ifdef APB_REQ_DECODE_EN
    localparam int NS = 4;
`else
    localparam int NS = 1;
`endif

    logic          clk = 1'b0;
    logic          nReset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [NS-1:0] sel;
    logic          enable;
    logic          write;
    logic [31:0]   addr;
    logic [31:0]   wData;
    logic [31:0]   rData;
    logic          subErr;

    int total = 0;
    int bad   = 0;
    logic [32:0] exp_q[$];
    logic [31:0] mem [16];

    always #5 clk = ~clk;

`ifdef APB_REQ_DECODE_EN
    apb_requester #(.AddrWidth(32), .DataWidth(32), .SubAddrWidth(4), .NumSubs(4)) dut (
`else
    apb_requester #(.AddrWidth(32), .DataWidth(32)) dut (
`endif
        .clk(clk), .nReset(nReset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .sel(sel), .enable(enable), .write(write), .addr(addr), .wData(wData),
        .rData(rData), .subErr(subErr)
    );

    // Peripheral: acts at the edge ending ACCESS; address 3 raises a sticky error.
    always @(posedge clk) begin
        if (|sel && enable) begin
            if (write) mem[addr[3:0]] <= wData;
            else       rData <= mem[addr[3:0]];
            if (addr[3:0] == 4'h3) subErr <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rsp_valid) begin
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL rsp_unexpected observed=%0h expected=none", {rsp_rdata, rsp_err});
            end
            if (exp_q.size() > 0) begin
                logic [32:0] e;
                e = exp_q.pop_front();
                total++;
                assert ({rsp_rdata, rsp_err} === e) else begin
                    bad++;
                    $error("FAIL rsp_data_err observed=%0h expected=%0h", {rsp_rdata, rsp_err}, e);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    // Full transfer from an idle cycle; leaves the bench in the response cycle.
    task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] erd, input logic eerr);
        drive(w, a, d);
        chk({tag, "_ready"}, 64'(req_ready), 64'd1);
        exp_q.push_back({erd, eerr});
        step();
        req_valid = 1'b0;
        repeat (3) step();
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[1]    = 32'h1234;
        rData     = '0;
        subErr    = 1'b0;
        nReset    = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) step();
        chk("reset_ready", 64'(req_ready), 64'd0);
        chk("reset_sel", 64'(sel), 64'd0);
        chk("reset_rsp", {31'd0, rsp_valid, rsp_rdata}, 64'd0);
        nReset = 1'b1;
        step();
        chk("idle_ready", 64'(req_ready), 64'd1);

        // Write 0xA5 to address 0, phase by phase
        drive(1'b1, 32'h0, 32'hA5);
        exp_q.push_back({32'h0, 1'b0});
        step();
        req_valid = 1'b0;
        chk("wr_setup", {sel == NS'(1), enable, write, addr[3:0], wData[7:0]}, {1'b1, 1'b0, 1'b1, 4'h0, 8'hA5});
        chk("wr_setup_ready", 64'(req_ready), 64'd0);
        step();
        chk("wr_access", {sel == NS'(1), enable, write, wData}, {1'b1, 1'b1, 1'b1, 32'hA5});
        step();
        chk("wr_capture", {31'd0, |sel, enable, write, wData}, 64'd0);
        step();
        chk("wr_rsp", {rsp_valid, req_ready}, 2'b11);

        xfer("rd1", 1'b0, 32'h1, 32'h0, 32'h1234, 1'b0);

        // req_valid held across two writes
        drive(1'b1, 32'h2, 32'h11);
        exp_q.push_back({32'h0, 1'b0});
        step();
        req_wdata = 32'h22;
        req_addr  = 32'h4;
        repeat (3) step();
        chk("b2b_rsp1", {rsp_valid, req_ready}, 2'b11);
        exp_q.push_back({32'h0, 1'b0});
        step();
        req_valid = 1'b0;
        chk("b2b_setup2", {sel == NS'(1), addr[3:0]}, {1'b1, 4'h4});
        repeat (3) step();
        chk("b2b_rsp2", 64'(rsp_valid), 64'd1);
        step();
        chk("mem_b2b", {mem[2], mem[4]}, {32'h11, 32'h22});

        // Sticky error: fails only the transfer that raised it
        xfer("err_rd3", 1'b0, 32'h3, 32'h0, 32'h0, 1'b1);
        xfer("sticky_rd0", 1'b0, 32'h0, 32'h0, 32'hA5, 1'b0);

        // Reset during ACCESS
        drive(1'b0, 32'h1, 32'h0);
        step();
        req_valid = 1'b0;
        step();
        chk("abort_in_access", 64'(enable), 64'd1);
        nReset = 1'b0;
        step();
        chk("abort_outputs", {sel != 0, enable, rsp_valid, req_ready}, 4'b0000);
        nReset = 1'b1;
        step();
        chk("abort_ready", 64'(req_ready), 64'd1);
        repeat (4) step();
        chk("abort_no_rsp", 64'(rsp_valid), 64'd0);

        xfer("post_rd1", 1'b0, 32'h1, 32'h0, 32'h1234, 1'b0);

`ifdef APB_REQ_DECODE_EN
        drive(1'b1, 32'h25, 32'h5A);
        exp_q.push_back({32'h0, 1'b0});
        step();
        req_valid = 1'b0;
        chk("dec_sel", {sel, addr}, {4'b0100, 32'h5});
        repeat (3) step();
        chk("dec_rsp", 64'(rsp_valid), 64'd1);
        drive(1'b0, 32'h45, 32'h0);
        exp_q.push_back({32'h0, 1'b1});
        step();
        req_valid = 1'b0;
        chk("decerr_setup_sel", 64'(sel), 64'd0);
        step();
        chk("decerr_access_sel", {sel, enable}, {4'b0000, 1'b1});
        repeat (2) step();
        chk("decerr_rsp", 64'(rsp_valid), 64'd1);
`endif

        step();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
